lfsr: RTL and testbench



---
 rtl/lfsr.sv | 37 +++
 tb/tb_lfsr.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lfsr.sv
// 16-bit Fibonacci LFSR pseudo-random word source.
// prn is the state register itself; polynomial x^16 + x^15 + x^13 + x^4 + 1 by default.
module lfsr #(
    parameter int unsigned     WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = 16'hD008,
    parameter logic [WIDTH-1:0] SEED = 16'h0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lfsr_enable,
    output logic [WIDTH-1:0] prn
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             fb;

    // Next state: shift toward MSB with XOR feedback into bit 0; escape the all-zero lock-up state.
    always_comb begin
        fb     = ^(q & TAPS);
        q_next = {q[WIDTH-2:0], fb};
        if (q == '0) begin
            q_next = WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= SEED;
        end else if (lfsr_enable) begin
            q <= q_next;
        end
    end

    assign prn = q;

endmodule

// File: tb/tb_lfsr.sv
// Scoreboarded random test of lfsr: default SEED instance plus an illegal SEED = 0 instance.
module tb_lfsr;

    localparam logic [15:0] TAPS   = 16'hD008;
    localparam logic [15:0] SEED_A = 16'h0001;
    localparam logic [15:0] SEED_B = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lfsr_enable = 1'b0;
    logic [15:0] prn_a;
    logic [15:0] prn_b;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          track;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    bit          seen[65536];
    int          distinct = 0;
    int          dups = 0;
    int          zeros = 0;
    logic [15:0] m_a;
    logic [15:0] m_b;

    always #5 clk = ~clk;

    lfsr #(.WIDTH(16), .TAPS(TAPS), .SEED(SEED_A)) dut_a (
        .clk(clk), .reset(reset), .lfsr_enable(lfsr_enable), .prn(prn_a)
    );

    lfsr #(.WIDTH(16), .TAPS(TAPS), .SEED(SEED_B)) dut_b (
        .clk(clk), .reset(reset), .lfsr_enable(lfsr_enable), .prn(prn_b)
    );

    // Reference: next value from the polynomial rule, reset priority and zero-escape rule.
    function automatic logic [15:0] model(input logic [15:0] cur, input logic r, input logic en,
                                          input logic [15:0] seed);
        int fbit;
        if (!r) return seed;
        if (!en) return cur;
        if (cur == 16'h0000) return 16'h0001;
        fbit = $countones(cur & TAPS) % 2;
        return 16'((int'(cur) * 2) % 65536 + fbit);
    endfunction

    // Drive one edge's inputs and queue the expected post-edge outputs.
    task automatic cycle(input logic r, input logic en, input bit track,
                         input bit use_tbl, input logic [15:0] tbl);
        exp_t e;
        @(negedge clk);
        reset       = r;
        lfsr_enable = en;
        m_a = model(m_a, r, en, SEED_A);
        m_b = model(m_b, r, en, SEED_B);
        e.a     = use_tbl ? tbl : m_a;
        e.b     = m_b;
        e.track = track;
        sb.push_back(e);
    endtask

    // Monitor: one output word per edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (prn_a !== e.a) begin
                errors++;
                $display("FAIL prn_seed1 t=%0t got=%h want=%h", $time, prn_a, e.a);
            end
            checks++;
            if (prn_b !== e.b) begin
                errors++;
                $display("FAIL prn_seed0 t=%0t got=%h want=%h", $time, prn_b, e.b);
            end
            if (e.track) begin
                if (prn_a === 16'h0000) zeros++;
                if (seen[prn_a]) dups++;
                else begin
                    seen[prn_a] = 1'b1;
                    distinct++;
                end
            end
        end
    end

    logic [15:0] first_steps [8];

    initial begin
        first_steps = '{16'h0002, 16'h0004, 16'h0008, 16'h0011,
                        16'h0022, 16'h0044, 16'h0088, 16'h0111};
        m_a = 16'hxxxx;
        m_b = 16'hxxxx;

        // Reset held with enable high: no advance.
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001);

        // First four steps, hold at 0x0011, then resume.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, first_steps[i]);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0011);
        for (int i = 4; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, first_steps[i]);

        // Full period from reset.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001);
        for (int i = 1; i < 65535; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0001);

        // ~1000 cycles with random enable, then a one-edge reset with enable high.
        for (int i = 0; i < 1000; i++) cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0002);

        // Random enable and occasional reset.
        for (int i = 0; i < 1000; i++)
            cycle(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0000);

        @(negedge clk);
        lfsr_enable = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        checks++;
        if (distinct != 65535) begin
            errors++;
            $display("FAIL period_distinct got=%0d want=65535", distinct);
        end
        checks++;
        if (dups != 0) begin
            errors++;
            $display("FAIL period_dups got=%0d want=0", dups);
        end
        checks++;
        if (zeros != 0) begin
            errors++;
            $display("FAIL period_zero got=%0d want=0", zeros);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
